// File: rtl/delta_sigma_array_pkg.sv
// Shared order encoding, sample-width helper and the input clamp/quantiser.
package delta_sigma_array_pkg;

    localparam logic ORDER_FIRST  = 1'b0;
    localparam logic ORDER_SECOND = 1'b1;

    function automatic int total_width(input int integer_bits, input int fraction_bits);
        return 1 + integer_bits + fraction_bits;
    endfunction

    // Sample arrives zero-extended to 64 bits; negative clamps to 0, >= 1.0 clamps to full scale.
    function automatic logic [63:0] clamp_code(input logic [63:0] sample, input int t_bits,
                                               input int f_bits, input int d_bits);
        logic [63:0] int_mask;
        logic [63:0] ds_mask;
        int_mask = (64'd1 << (t_bits - 1 - f_bits)) - 64'd1;
        ds_mask  = (64'd1 << d_bits) - 64'd1;
        if (sample[t_bits-1])
            return 64'd0;
        else if (((sample >> f_bits) & int_mask) != 64'd0)
            return ds_mask;
        else
            return (sample >> (f_bits - d_bits)) & ds_mask;
    endfunction

endpackage

// File: rtl/delta_sigma_channel.sv
// One DAC channel: first- or second-order modulator on an unsigned code.
// Pin is registered; a code change affects the pin one cycle later.
module delta_sigma_channel
    import delta_sigma_array_pkg::*;
#(
    parameter int dsBits = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [dsBits-1:0] code,
    input  logic              order,
    input  logic              clear,
    output logic              pin
);

    localparam int W = dsBits + 4;
    localparam int E = W + 2;
    localparam logic signed [E-1:0] FB_ONE  = {{(E-dsBits-1){1'b0}}, 1'b1, {dsBits{1'b0}}};
    localparam logic signed [E-1:0] SAT_MAX = {{(E-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [E-1:0] SAT_MIN = {{(E-W+1){1'b1}}, {(W-1){1'b0}}};

    // The first-order carry bit lives in pin, so acc only keeps the low dsBits.
    logic [dsBits-1:0]   acc;
    logic [dsBits:0]     acc_sum;
    logic signed [W-1:0] i1, i2, i1_next, i2_next;
    logic signed [E-1:0] code_e, fb_e, i1_sum, i2_sum;

    function automatic logic signed [W-1:0] sat(input logic signed [E-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return v[W-1:0];
    endfunction

    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, code};
        code_e  = {{(E-dsBits){1'b0}}, code};
        fb_e    = pin ? FB_ONE : '0;
        i1_sum  = {{(E-W){i1[W-1]}}, i1} + code_e - fb_e;
        i1_next = sat(i1_sum);
        i2_sum  = {{(E-W){i2[W-1]}}, i2} + {{(E-W){i1_next[W-1]}}, i1_next} - fb_e;
        i2_next = sat(i2_sum);
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            acc <= '0;
            i1  <= '0;
            i2  <= '0;
            pin <= 1'b0;
        end else if (order == ORDER_SECOND) begin
            i1  <= i1_next;
            i2  <= i2_next;
            pin <= !i2_next[W-1];
        end else begin
            acc <= acc_sum[dsBits-1:0];
            pin <= acc_sum[dsBits];
        end
    end

endmodule

// File: rtl/delta_sigma_array.sv
// N-channel delta-sigma output stage; samples wait in a pending slot and go live together at the frame tick.
// Accept-to-active is up to one frame plus a cycle; sampleReady drops while pending is full, except on the tick.
module delta_sigma_array
    import delta_sigma_array_pkg::*;
#(
    parameter int channels     = 2,
    parameter int integerBits  = 6,
    parameter int fractionBits = 25,
    parameter int dsBits       = 16,
    parameter int tickBits     = 8
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic [channels*total_width(integerBits, fractionBits)-1:0] sampleIn,
    input  logic                                                     sampleValid,
    output logic                                                     sampleReady,
    input  logic                                                     order,
    output logic [15:0]                                              underrun,
    output logic [channels-1:0]                                      pins
);

    localparam int T = total_width(integerBits, fractionBits);

    logic [tickBits-1:0] tick_cnt;
    logic                tick, pend_full, order_q, accept, clear;
    logic [dsBits-1:0]   in_code   [channels];
    logic [dsBits-1:0]   pend_code [channels];
    logic [dsBits-1:0]   act_code  [channels];

    assign tick        = &tick_cnt;
    assign sampleReady = !pend_full || tick;
    assign accept      = sampleValid && sampleReady;
    assign clear       = tick && pend_full && (order != order_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt  <= '0;
            pend_full <= 1'b0;
            order_q   <= ORDER_FIRST;
            underrun  <= '0;
            for (int k = 0; k < channels; k++) begin
                pend_code[k] <= '0;
                act_code[k]  <= '0;
            end
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            underrun <= (tick && !pend_full && underrun != 16'hFFFF) ? underrun + 16'd1 : underrun;
            if (tick && pend_full) begin
                act_code <= pend_code;
                order_q  <= order;
            end
            // A tick drains the slot, and the same cycle may refill it.
            if (accept) begin
                pend_code <= in_code;
                pend_full <= 1'b1;
            end else if (tick) begin
                pend_full <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < channels; k++) begin : g_ch
        assign in_code[k] = dsBits'(clamp_code(64'(sampleIn[k*T +: T]), T, fractionBits, dsBits));

        delta_sigma_channel #(
            .dsBits(dsBits)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .code (act_code[k]),
            .order(order_q),
            .clear(clear),
            .pin  (pins[k])
        );
    end

endmodule
